memory_stage_param: RTL
=======================

# memory_stage_param

Parametrised successor of the pipeline MEM stage. It generalises the data path to XLEN 32 or 64 with a B/H/W/D access size, and adds signed and unsigned loads. Accesses that cross a memory-word boundary are split into two transactions and stall the upstream pipeline for one cycle. It sits between the EX→MEM and MEM→WB boundaries and owns the data memory and the MEM→WB pipeline register.

## Interface
- XLEN, 64: data width; legal values are 32 and 64. LANES = XLEN/8 byte lanes.
- ADDR_W, 12: memory word-address width; depth is 2^ADDR_W words of XLEN bits.
- clk in 1: single clock; all state updates on the rising edge.
- rst_n in 1: asynchronous, active-low reset.
- RegWriteEnM, MemtoRegM, JALM in 1 each: control bits forwarded to WB.
- MemReadEnM, MemWriteEnM in 1 each: load and store request. Both set is illegal; treat it as a store.
- MemSizeM in 2: access size for loads and stores. 00=B, 01=H, 10=W, 11=D. D with XLEN=32 is treated as W.
- LoadUnsignedM in 1: 1 means zero-extend (LBU/LHU/LWU), 0 means sign-extend.
- RdM in 5; PcPlus4M, ReadData2M, ALUResultM in XLEN: destination, link value, store data and byte address.
- StallM out 1: hold EX→MEM; asserted during the first half of a split access.
- RegWriteEnW, MemtoRegW, JALW out 1 each; RdW out 5; PcPlus4W, ALUResultW, ReadDataW out XLEN.

## Operation
- Byte offset is off = ALUResultM[log2(LANES)-1:0]. Word address is wa = ALUResultM[ADDR_W+log2(LANES)-1:log2(LANES)]. Higher address bits are ignored.
- Access size in bytes is n = 1, 2, 4 or 8.
- An access is aligned-in-word when off+n ≤ LANES. Otherwise it is split.
  - Low part: lanes off..LANES-1 at wa.
  - High part: lanes 0..(off+n-LANES-1) at wa+1, modulo depth, so the last word wraps to word 0.
- Store: ReadData2M[8n-1:0] is rotated left by off bytes, modulo LANES. A lane's write enable is set only if that lane is covered by the current part.
- Load: the read returns a full word. WB-side formatting rotates right by the registered offset, masks to n bytes, then sign- or zero-extends to XLEN.
- FSM states:
  - IDLE: aligned access, or no access. Issue the access; StallM=0; the W register loads the M inputs.
  - IDLE→SPLIT: a split access is detected. Issue the low part and set StallM=1. The W register loads a bubble (all control outputs 0). Latch off, n, unsigned and wa.
  - SPLIT: issue the high part at latched wa+1 and set StallM=0. Capture the low-part read word into the hold register. The W register loads the M inputs, which upstream has held stable. Return to IDLE.
- Split loads: ReadDataW is assembled from the hold word (low bytes) and the current RAM word (high bytes).
- Read-during-write to the same lane and word returns the old data.
- ReadDataW is a don't-care when MemtoRegW=0. Bench compares only when MemtoRegW=1.

## Timing
- RAM has a synchronous write and a registered read: address at edge k, q valid after edge k.
- Aligned load: request in M cycle k. RegWriteEnW, RdW and ReadDataW are all valid together in cycle k+1, with no extra latency.
- Split access: one stall cycle. Request is in M for cycles k and k+1; W shows a bubble at k+1 and the instruction at k+2.
- Stores are committed at the issuing edge. A split store writes its low part at edge k and its high part at edge k+1.
- Back-to-back accesses: a load immediately after a store to the same address sees the stored data.
- Reset (rst_n=0, asynchronous):
  - FSM goes to IDLE and StallM=0.
  - All W outputs are 0; the hold register is 0.
  - RAM contents are not reset.
- Reset asserted while in SPLIT: the high part is abandoned and only the low part of a store remains written.
- An access with neither read nor write still advances the W register. There is no RAM enable, so no power gating is applied.

## Structure
- Shared package mem_pkg:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D;
  - FSM state type {IDLE, SPLIT};
  - functions size_bytes() and lane_mask(off, n).
- Sub-module byte_lane_ram (ADDR_W parameter; 8-bit data; wren; registered q), instantiated LANES times by a generate loop.
- Everything else lives in memory_stage_param: store rotation, mask logic, FSM, W register and load formatter.

## Test plan
- XLEN=64: SD 0x1122334455667788 to addr 0x40, then LD from 0x40 → ReadDataW=0x1122334455667788 one cycle after the LD, with StallM=0 throughout.
- SB 0x80 to addr 0x45, then LB from 0x45 → 0xFFFFFFFFFFFFFF80; LBU from 0x45 → 0x80; bytes 0x40-0x44 and 0x46-0x47 unchanged.
- Split SW 0xDEADBEEF to addr 0x46 → StallM high for exactly 1 cycle and W shows a bubble. Then LW from 0x46 → 0xFFFFFFFFDEADBEEF and LWU → 0xDEADBEEF. Word 0x40 bytes 6-7 are 0xEF/0xBE; word 0x48 bytes 0-1 are 0xAD/0xDE.
- Split LD at the last word (off=4, wa=max) → the high part is read from word 0 (wrap-around).
- XLEN=32 build: D-size access behaves as W; SH at offset 3 splits; LH sign-extends 0x8001 → 0xFFFF8001.
- Drop rst_n during SPLIT of a split store → W outputs are 0 and StallM=0 immediately. The low part is written; the high-part bytes keep their previous values.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings, FSM state type and lane helpers for the parametrised MEM stage.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic {IDLE, SPLIT} state_e;

  // MEM->WB register contents; data fields are sized for the widest build
  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        jal;
    logic [4:0]  rd;
    logic [63:0] pc_plus4;
    logic [63:0] alu;
    logic [2:0]  off;
    logic [3:0]  n;
    logic        uns;
    logic        split;
  } wb_t;

  function automatic logic [3:0] size_bytes(input logic [1:0] sz, input logic wide);
    case (sz)
      SZ_B:    return 4'd1;
      SZ_H:    return 4'd2;
      SZ_W:    return 4'd4;
      default: return wide ? 4'd8 : 4'd4;
    endcase
  endfunction

  // Bits [LANES-1:0] cover the addressed word, bits above spill into the next word
  function automatic logic [15:0] lane_mask(input logic [2:0] off, input logic [3:0] n);
    logic [15:0] ones;
    ones = (16'h1 << n) - 16'h1;
    return ones << off;
  endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// One byte lane of the data memory: synchronous write, registered read-old-data.
module byte_lane_ram #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              wren_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (wren_i) begin
      mem[addr_i] <= wdata_i;
    end
    rdata_o <= mem[addr_i];
  end

endmodule

// File: rtl/memory_stage_param.sv
// Parametrised MEM stage: byte-lane data memory, split-access FSM, MEM->WB register
// and load formatter.
module memory_stage_param
  import mem_pkg::*;
#(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned ADDR_W = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            RegWriteEnM,
  input  logic            MemtoRegM,
  input  logic            JALM,
  input  logic            MemReadEnM,
  input  logic            MemWriteEnM,
  input  logic [1:0]      MemSizeM,
  input  logic            LoadUnsignedM,
  input  logic [4:0]      RdM,
  input  logic [XLEN-1:0] PcPlus4M,
  input  logic [XLEN-1:0] ReadData2M,
  input  logic [XLEN-1:0] ALUResultM,
  output logic            StallM,
  output logic            RegWriteEnW,
  output logic            MemtoRegW,
  output logic            JALW,
  output logic [4:0]      RdW,
  output logic [XLEN-1:0] PcPlus4W,
  output logic [XLEN-1:0] ALUResultW,
  output logic [XLEN-1:0] ReadDataW
);

  localparam int unsigned LANES = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(LANES);

  state_e            state_q, state_d;
  logic [OFF_W-1:0]  off_m, off_q, off_d, off_use;
  logic [ADDR_W-1:0] wa_m, wa_q, wa_d, ram_addr;
  logic [3:0]        n_m, n_q, n_d, n_use;
  logic              uns_q, uns_d, uns_use;
  logic [15:0]       mask;
  logic [LANES-1:0]  lo_mask, hi_mask, lane_we;
  logic [XLEN-1:0]   lane_wdata, ram_q, hold_q, hold_d;
  logic [XLEN-1:0]   joined, rotated, loaded;
  logic              access, split_req, bubble, sign;
  wb_t               wb_q, wb_d;
  logic              unused_sig;

  assign off_m     = ALUResultM[OFF_W-1:0];
  assign wa_m      = ALUResultM[ADDR_W+OFF_W-1:OFF_W];
  assign n_m       = size_bytes(MemSizeM, XLEN == 64);
  assign access    = MemReadEnM | MemWriteEnM;
  assign unused_sig = ^{ALUResultM, wb_q.pc_plus4, wb_q.alu, mask};

  // While in SPLIT the latched request drives the datapath
  always_comb begin
    off_use  = off_m;
    n_use    = n_m;
    uns_use  = LoadUnsignedM;
    ram_addr = wa_m;
    if (state_q == SPLIT) begin
      off_use  = off_q;
      n_use    = n_q;
      uns_use  = uns_q;
      ram_addr = wa_q + ADDR_W'(1);
    end
  end

  assign mask      = lane_mask(3'(off_use), n_use);
  assign lo_mask   = mask[LANES-1:0];
  assign hi_mask   = mask[2*LANES-1:LANES];
  assign split_req = access & (|hi_mask);

  always_comb begin
    lane_wdata = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_wdata[8*i +: 8] = ReadData2M[8*((i + LANES - 32'(off_use)) % LANES) +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    wa_d    = wa_q;
    n_d     = n_q;
    uns_d   = uns_q;
    hold_d  = hold_q;
    lane_we = '0;
    StallM  = 1'b0;
    bubble  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (MemWriteEnM) lane_we = lo_mask;
        if (split_req) begin
          state_d = SPLIT;
          StallM  = 1'b1;
          bubble  = 1'b1;
          off_d   = off_m;
          wa_d    = wa_m;
          n_d     = n_m;
          uns_d   = LoadUnsignedM;
        end
      end
      SPLIT: begin
        if (MemWriteEnM) lane_we = hi_mask;
        hold_d  = ram_q;
        state_d = IDLE;
      end
    endcase
    // Nothing is issued while reset is held
    if (!rst_n) begin
      lane_we = '0;
      StallM  = 1'b0;
    end
  end

  always_comb begin
    wb_d = '0;
    if (!bubble) begin
      wb_d.reg_write  = RegWriteEnM;
      wb_d.mem_to_reg = MemtoRegM;
      wb_d.jal        = JALM;
      wb_d.rd         = RdM;
      wb_d.pc_plus4   = 64'(PcPlus4M);
      wb_d.alu        = 64'(ALUResultM);
      wb_d.off        = 3'(off_use);
      wb_d.n          = n_use;
      wb_d.uns        = uns_use;
      wb_d.split      = (state_q == SPLIT);
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    byte_lane_ram #(
      .ADDR_W (ADDR_W)
    ) u_ram (
      .clk_i   (clk),
      .wren_i  (lane_we[g]),
      .addr_i  (ram_addr),
      .wdata_i (lane_wdata[8*g +: 8]),
      .rdata_o (ram_q[8*g +: 8])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      off_q   <= '0;
      wa_q    <= '0;
      n_q     <= '0;
      uns_q   <= 1'b0;
      hold_q  <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      wa_q    <= wa_d;
      n_q     <= n_d;
      uns_q   <= uns_d;
      hold_q  <= hold_d;
      wb_q    <= wb_d;
    end
  end

  // Split loads take lanes at/above the offset from the hold word, the rest from the RAM
  always_comb begin
    joined  = '0;
    rotated = '0;
    loaded  = '0;
    sign    = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      joined[8*i +: 8] = (wb_q.split && i >= 32'(wb_q.off)) ? hold_q[8*i +: 8] : ram_q[8*i +: 8];
    end
    for (int unsigned i = 0; i < LANES; i++) begin
      rotated[8*i +: 8] = joined[8*((i + 32'(wb_q.off)) % LANES) +: 8];
    end
    for (int unsigned i = 0; i < LANES; i++) begin
      if (i + 1 == 32'(wb_q.n)) sign = rotated[8*i+7];
    end
    for (int unsigned i = 0; i < LANES; i++) begin
      loaded[8*i +: 8] = (i < 32'(wb_q.n)) ? rotated[8*i +: 8] : {8{sign & ~wb_q.uns}};
    end
  end

  assign RegWriteEnW = wb_q.reg_write;
  assign MemtoRegW   = wb_q.mem_to_reg;
  assign JALW        = wb_q.jal;
  assign RdW         = wb_q.rd;
  assign PcPlus4W    = wb_q.pc_plus4[XLEN-1:0];
  assign ALUResultW  = wb_q.alu[XLEN-1:0];
  assign ReadDataW   = wb_q.mem_to_reg ? loaded : '0;

endmodule
